// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: clocked round-robin merge of N four-phase req/grant channels onto one upstream four-phase channel
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req[N]        four-phase requests (held until grant, released after grant)
//   grant[N]      registered one-hot-or-zero grants
//   up_req        registered upstream request
//   up_ack        upstream acknowledge
//   busy          high whenever the handshake FSM is not idle
//   grant_id      index of the current or last winner
//   err           sticky upstream-handshake timeout flag
module hs_rr_arbiter #(
   parameter int N = 2,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT = 0,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic          up_req,
   input  logic          up_ack,
   output logic          busy,
   output logic [IW-1:0] grant_id,
   output logic          err
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] REL  = 2'd3;
   logic [1:0]    state;
   logic [N-1:0]  req_s;
   logic          ack_s;
   logic [IW-1:0] ptr, off, win;
   logic [N-1:0]  rot;
   if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req;
      assign ack_s = up_ack;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0][N-1:0] req_ff;
      logic [SYNC_STAGES-1:0]        ack_ff;
      always_ff @(posedge clk) begin
         if (rst) begin
            req_ff <= '0;
            ack_ff <= '0;
         end else begin
            req_ff[0] <= req;
            ack_ff[0] <= up_ack;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               req_ff[i] <= req_ff[i-1];
               ack_ff[i] <= ack_ff[i-1];
            end
         end
      end
      assign req_s = req_ff[SYNC_STAGES-1];
      assign ack_s = ack_ff[SYNC_STAGES-1];
   end
   // rotate so bit 0 is the ptr position; the lowest set bit is the offset of the winner from ptr
   always_comb begin
      rot = N'({req_s, req_s} >> ptr);
      off = '0;
      for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
      win = IW'((int'(ptr) + int'(off)) % N);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         up_req   <= 1'b0;
         grant_id <= '0;
         ptr      <= '0;
      end else begin
         case (state)
            IDLE: if (|req_s) begin
               grant_id <= win;
               up_req   <= 1'b1;
               state    <= REQ;
            end
            REQ: if (ack_s) begin
               grant <= N'(1) << grant_id;
               state <= HOLD;
            end
            HOLD: if (!req_s[grant_id]) begin
               up_req <= 1'b0;
               state  <= REL;
            end
            REL: if (!ack_s) begin
               grant <= '0;
               ptr   <= IW'((int'(grant_id) + 1) % N);
               state <= IDLE;
            end
         endcase
      end
   end
   assign busy = state != IDLE;
   if (TIMEOUT == 0) begin : g_noto
      assign err = 1'b0;
   end else begin : g_to
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;
      logic          waiting;
      // leaving a wait state (or never being in one) clears the count, so every entry starts at zero
      assign waiting = (state == REQ && !ack_s) || (state == REL && ack_s);
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
            err <= 1'b0;
         end else if (!waiting) begin
            cnt <= '0;
         end else begin
            cnt <= (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
            if (cnt == CW'(TIMEOUT - 1)) err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: directed and randomized checks of hs_rr_arbiter against a cycle-level reference model
module tb_hs_rr_arbiter;
   localparam int N  = 2;
   localparam int SS = 2;
   localparam int TO = 8;
   localparam int M_IDLE = 0, M_REQ = 1, M_HOLD = 2, M_REL = 3;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant;
   logic         up_req;
   logic         up_ack = 1'b0;
   logic         busy;
   logic [0:0]   grant_id;
   logic         err;
   int n_chk = 0;
   int n_err = 0;
   // reference model: spec-level phase, pointer, winner, timeout tally and input delay lines
   int m_st, m_ptr, m_id, m_wait;
   logic m_err;
   logic [N-1:0] rq[$];
   logic         aq[$];
   // upstream responder
   bit resp_on = 0;
   bit resp_rand = 0;
   int rdelay = 3;
   int rcnt = 3;
   hs_rr_arbiter #(.N(N), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant), .up_req(up_req),
      .up_ack(up_ack), .busy(busy), .grant_id(grant_id), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return p;
   endfunction
   task automatic model_reset();
      m_st = M_IDLE; m_ptr = 0; m_id = 0; m_wait = 0; m_err = 1'b0;
      rq.delete(); aq.delete();
      for (int i = 0; i < SS; i++) begin rq.push_back('0); aq.push_back(1'b0); end
   endtask
   task automatic wait_tally();
      m_wait++;
      if (m_wait >= TO) m_err = 1'b1;
   endtask
   task automatic model_step();
      logic [N-1:0] rs;
      logic as;
      if (rst) begin
         model_reset();
         return;
      end
      rq.push_front(req); aq.push_front(up_ack);
      rs = rq[SS]; as = aq[SS];
      void'(rq.pop_back()); void'(aq.pop_back());
      if (m_st == M_IDLE) begin
         if (rs != 0) begin m_id = pick(rs, m_ptr); m_st = M_REQ; m_wait = 0; end
      end else if (m_st == M_REQ) begin
         if (as) m_st = M_HOLD; else wait_tally();
      end else if (m_st == M_HOLD) begin
         if (!rs[m_id]) begin m_st = M_REL; m_wait = 0; end
      end else begin
         if (!as) begin m_st = M_IDLE; m_ptr = (m_id + 1) % N; end else wait_tally();
      end
   endtask
   task automatic tick();
      logic [N-1:0] m_grant;
      if (resp_on && up_ack !== up_req) begin
         if (rcnt == 0) begin
            up_ack = up_req;
            rdelay = resp_rand ? (($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 3)) : rdelay;
            rcnt = rdelay;
         end else rcnt--;
      end
      @(posedge clk);
      model_step();
      #1;
      m_grant = (m_st == M_HOLD || m_st == M_REL) ? N'(1) << m_id : '0;
      chk("grant", grant, m_grant);
      chk("up_req", up_req, m_st == M_REQ || m_st == M_HOLD);
      chk("busy", busy, m_st != M_IDLE);
      chk("grant_id", grant_id, m_id);
      chk("err", err, m_err);
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic wait_grant(input logic [N-1:0] want, input string tag);
      int n = 0;
      while (grant !== want && n < 200) begin tick(); n++; end
      chk(tag, grant, want);
   endtask
   task automatic wait_any(output logic [N-1:0] g);
      int n = 0;
      while (grant === '0 && n < 200) begin tick(); n++; end
      chk("wait_any_bound", n < 200, 1);
      g = grant;
   endtask
   task automatic do_reset();
      rst = 1'b1; up_ack = 1'b0; rcnt = rdelay;
      tick();
      rst = 1'b0;
   endtask
   initial begin
      logic [N-1:0] g;
      model_reset();
      // reset state
      rst = 1'b1;
      ticks(2);
      chk("rst_grant", grant, 0);
      chk("rst_up_req", up_req, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      ticks(2);
      // up_ack tied low: request latency and timeout
      req = 2'b01;
      ticks(2);
      chk("up_req_early", up_req, 0);
      tick();
      chk("up_req_lat", up_req, 1);
      ticks(7);
      chk("err_before_to", err, 0);
      tick();
      chk("err_at_to", err, 1);
      chk("no_grant_wo_ack", grant, 0);
      chk("busy_in_req", busy, 1);
      req = '0;
      do_reset();
      chk("err_cleared", err, 0);
      // full handshake with upstream echoing after 3 cycles
      resp_on = 1; rdelay = 3; rcnt = 3;
      req = 2'b01;
      wait_grant(2'b01, "hs_grant");
      req = 2'b00;
      wait_grant(2'b00, "hs_release");
      chk("hs_idle", busy, 0);
      chk("hs_id", grant_id, 0);
      chk("hs_up_req", up_req, 0);
      // simultaneous requests from reset
      do_reset();
      req = 2'b11;
      wait_grant(2'b01, "simul_first");
      req[0] = 1'b0;
      wait_grant(2'b00, "simul_rel");
      wait_grant(2'b10, "simul_second");
      chk("simul_id", grant_id, 1);
      req[1] = 1'b0;
      wait_grant(2'b00, "simul_done");
      // fairness under constant contention
      for (int h = 0; h < 6; h++) begin
         req = 2'b11;
         wait_any(g);
         chk($sformatf("fair_%0d", h), g, (h % 2) ? 2'b10 : 2'b01);
         req = req & ~g;
         wait_grant(2'b00, "fair_rel");
      end
      req = 2'b00;
      ticks(4);
      // request arriving mid-HOLD is not lost
      req = 2'b10;
      wait_grant(2'b10, "late_first");
      req = 2'b11;
      ticks(2);
      req = 2'b01;
      wait_grant(2'b00, "late_rel");
      wait_grant(2'b01, "late_not_lost");
      req = 2'b00;
      wait_grant(2'b00, "late_done");
      // reset during HOLD aborts and restores ptr=0
      req = 2'b11;
      wait_any(g);
      chk("pre_rst_up_req", up_req, 1);
      do_reset();
      chk("abort_grant", grant, 0);
      chk("abort_up_req", up_req, 0);
      chk("abort_err", err, 0);
      wait_any(g);
      chk("post_rst_first", g, 2'b01);
      // randomized requesters and upstream, including early withdrawals
      resp_rand = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && !grant[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            else if (req[i] && grant[i] && $urandom_range(0, 2) == 0) req[i] = 1'b0;
            else if (req[i] && !grant[i] && $urandom_range(0, 99) == 0) req[i] = 1'b0;
         end
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
Clocked round-robin arbiter that merges N four-phase (return-to-zero) request/grant channels onto one shared upstream four-phase channel (up_req/up_ack). It is a synchronous, parameterisable replacement for the two-way handshake arbiter element and can be cascaded into trees: one node's up_req/up_ack pair connects to a parent node's req[i]/grant[i]. Optional input synchronisers allow requesters and upstream to sit in other clock domains.

Parameters:
N, 2, number of requesters (2..16)
SYNC_STAGES, 2, flop stages on req and up_ack inputs (0 = inputs already synchronous)
TIMEOUT, 0, cycles to wait for an up_ack edge before setting err (0 = check disabled)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req  input  N  requests, one per requester; four-phase, held until grant, released after grant
grant  output  N  one-hot-or-zero grants, registered
up_req  output  1  upstream request, registered
up_ack  input  1  upstream acknowledge
busy  output  1  high in any state other than IDLE
grant_id  output  clog2(N) (min 1)  index of the current or last winner
err  output  1  sticky handshake-timeout flag

Behaviour:
- Reset (rst high at a clk edge): grant=0, up_req=0, busy=0, grant_id=0, err=0, rr pointer=0, sync flops=0, FSM=IDLE. Reset mid-handshake aborts immediately, with no orderly release.
- req_s / ack_s = req / up_ack after SYNC_STAGES flops. The FSM sees only req_s / ack_s.
- Arbitration: winner = first set bit of req_s scanning ptr, ptr+1, … wrapping at N-1→0. ptr becomes winner+1 (mod N) on return to IDLE.
- FSM states:
  - IDLE: grant=0, up_req=0. If req_s≠0, latch winner into grant_id, go to REQ.
  - REQ: up_req=1. When ack_s=1, set grant[grant_id]=1 and go to HOLD.
  - HOLD: up_req=1, grant held. When req_s[grant_id]=0, set up_req=0 and go to REL.
  - REL: up_req=0, grant held. When ack_s=0, set grant=0, advance ptr, go to IDLE.
- Latency (edges counted from the first edge at which the input is sampled high):
  - up_req rises after edge SYNC_STAGES (req rises).
  - grant rises after edge SYNC_STAGES (up_ack rises).
  - up_req falls after edge SYNC_STAGES (req falls).
  - grant falls after edge SYNC_STAGES (up_ack falls).
  - IDLE→REQ for the next request takes at least 1 extra cycle. No back-to-back bypass.
- Requests arriving during a busy cycle wait; they are never lost while held.
- Simultaneous requests are resolved by ptr only. No fixed priority.
- Request withdrawn before grant (protocol violation): the upstream cycle still completes. grant[grant_id] asserts for ≥1 cycle in HOLD, then the FSM proceeds to REL normally.
- Timeout: a counter runs in REQ (waiting for ack_s=1) and REL (waiting for ack_s=0). It clears on state entry. At count==TIMEOUT, err=1 (sticky until rst). The FSM keeps waiting; there is no abort. Counter width is clog2(TIMEOUT+1) and it saturates.
- At most one grant bit is ever high. up_req and grant never change in the same cycle as the sampled input edge that causes them (all outputs are registered).

Test Plan:
- N=2, SYNC_STAGES=2, up_ack tied low, req=00 then 01 -> up_req=1 two edges after req, grant stays 00, busy=1. With TIMEOUT=8, err=1 after 8 cycles in REQ.
- Full handshake: req=01, up_ack echoes up_req after 3 cycles -> grant=01 two edges after up_ack. req→00 -> up_req=0. up_ack→0 -> grant=00, busy=0, grant_id=0.
- Simultaneous req=11 from reset -> first grant=01 (ptr=0). After release, with req[1] still high -> grant=10, grant_id=1.
- Fairness: req=11 held and re-asserted each cycle for 6 handshakes -> grants alternate 01,10,01,10,01,10.
- req=10 only, then req=11 issued mid-HOLD -> grant=10 completes, then grant=01. req[0] is not lost.
- Reset asserted in HOLD -> next cycle grant=00, up_req=0, err=0, ptr=0. Subsequent req=11 -> grant=01 first.
